// File: rtl/ex_muldiv.sv
// Iterative MIPS-style HI/LO multiply/divide unit for the EX stage (34 edges per operation).
// Optional MULDIV_FAST_MUL_EN: MULT/MULTU complete in one cycle on a combinational multiplier.
module ex_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg;
    logic [31:0] acc_hi_reg, acc_lo_reg, operand_reg;
    logic        is_div_reg, neg_res_reg, neg_rem_reg;
    logic [31:0] hi_reg, lo_reg;
    logic        done_reg, dbz_reg;

    logic        op_div, op_signed;
    logic [31:0] mag_a, mag_b;
    logic        accept, div_zero, fast_mul, begin_calc, fix_write;

    assign op_div    = op[1];
    assign op_signed = ~op[0];
    assign mag_a     = (op_signed && src_a[31]) ? -src_a : src_a;
    assign mag_b     = (op_signed && src_b[31]) ? -src_b : src_b;
    assign accept    = (state_reg == IDLE) && start && !flush;
    assign div_zero  = accept && op_div && (src_b == 32'd0);

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] ext_a, ext_b, fast_prod;
    assign ext_a     = op_signed ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
    assign ext_b     = op_signed ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
    assign fast_prod = ext_a * ext_b;
    assign fast_mul  = accept && !op_div;
`else
    assign fast_mul  = 1'b0;
`endif

    assign begin_calc = accept && !div_zero && !fast_mul;
    assign fix_write  = (state_reg == FIX) && !flush;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (begin_calc) state_next = CALC;
            CALC:    if (flush) state_next = IDLE;
                     else if (count_reg == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiply: shift-add with the multiplier shifting out of acc_lo and the product filling in from the top.
    logic [32:0] add_sum;
    logic [31:0] mul_hi_next, mul_lo_next;
    assign add_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, operand_reg} : 33'd0);
    assign mul_hi_next = add_sum[32:1];
    assign mul_lo_next = {add_sum[0], acc_lo_reg[31:1]};

    // Divide: restoring; acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    logic [32:0] shifted;
    logic [33:0] diff;
    logic [31:0] div_hi_next, div_lo_next;
    assign shifted     = {acc_hi_reg, acc_lo_reg[31]};
    assign diff        = {1'b0, shifted} - {2'b00, operand_reg};
    assign div_hi_next = diff[33] ? shifted[31:0] : diff[31:0];
    assign div_lo_next = {acc_lo_reg[30:0], ~diff[33]};

    logic [63:0] prod_raw, prod_fix;
    logic [31:0] quot_fix, rem_fix;
    assign prod_raw = {acc_hi_reg, acc_lo_reg};
    assign prod_fix = neg_res_reg ? -prod_raw : prod_raw;
    assign quot_fix = neg_res_reg ? -acc_lo_reg : acc_lo_reg;
    assign rem_fix  = neg_rem_reg ? -acc_hi_reg : acc_hi_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            count_reg   <= 5'd0;
            acc_hi_reg  <= 32'd0;
            acc_lo_reg  <= 32'd0;
            operand_reg <= 32'd0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            done_reg    <= 1'b0;
            dbz_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            dbz_reg   <= 1'b0;
            if (state_reg == IDLE) begin
                if (hi_we) hi_reg <= wdata;
                if (lo_we) lo_reg <= wdata;
            end
            if (begin_calc) begin
                acc_hi_reg  <= 32'd0;
                acc_lo_reg  <= mag_a;
                operand_reg <= mag_b;
                count_reg   <= 5'd0;
                is_div_reg  <= op_div;
                neg_res_reg <= op_signed && (src_a[31] ^ src_b[31]);
                neg_rem_reg <= op_signed && src_a[31];
            end
            if (div_zero) begin
                done_reg <= 1'b1;
                dbz_reg  <= 1'b1;
            end
`ifdef MULDIV_FAST_MUL_EN
            // Placed after the MTHI/MTLO writes so a same-cycle product wins.
            if (fast_mul) begin
                hi_reg   <= fast_prod[63:32];
                lo_reg   <= fast_prod[31:0];
                done_reg <= 1'b1;
            end
`endif
            if (state_reg == CALC) begin
                count_reg  <= count_reg + 5'd1;
                acc_hi_reg <= is_div_reg ? div_hi_next : mul_hi_next;
                acc_lo_reg <= is_div_reg ? div_lo_next : mul_lo_next;
            end
            if (fix_write) begin
                hi_reg   <= is_div_reg ? rem_fix  : prod_fix[63:32];
                lo_reg   <= is_div_reg ? quot_fix : prod_fix[31:0];
                done_reg <= 1'b1;
            end
        end
    end

    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign busy        = (state_reg != IDLE);
    assign stall       = busy | (start & ~flush);
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports: clk, reset.
REQ-002 clk  in  1  rising-edge clock shared with the pipeline registers.
REQ-003 reset  in  1  asynchronous, active-low (0 = reset).
REQ-004 start  in  1  EX-stage request, decoded from id_ex_instruction.
REQ-005 op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 src_a  in  32  forwarded rs operand.
REQ-007 src_b  in  32  forwarded rt operand.
REQ-008 flush  in  1  abort any operation in progress.
REQ-009 hi_we, lo_we  in  1 each  MTHI/MTLO write enables.
REQ-010 wdata  in  32  MTHI/MTLO write data.
REQ-011 hi, lo  out  32 each  registered HI/LO.
REQ-012 busy  out  1  state != IDLE.
REQ-013 stall  out  1  combinational busy | (start & ~flush); holds IF_ID/ID_EX.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 div_by_zero  out  1  one-cycle pulse, coincident with done.

Function
REQ-016 The FSM SHALL have states IDLE, CALC and FIX.
REQ-017 In IDLE, start=1 with flush=0 SHALL be sampled at edge E0: it captures operand magnitudes and sign flags, sets count=0 and enters CALC.
REQ-018 CALC SHALL perform one radix-2 iteration per edge (shift-add for multiply, restoring subtract for divide) and go to FIX after 32 iterations (E1..E32).
REQ-019 FIX SHALL apply the sign correction, write HI/LO at E33 and return to IDLE; done SHALL be 1 for the cycle after E33.
REQ-020 Multiply SHALL produce HI:LO = the 64-bit product, signed for MULT and unsigned for MULTU.
REQ-021 Divide SHALL produce LO = quotient and HI = remainder, both truncated toward zero.
REQ-022 For signed divide, the quotient sign SHALL be sign(a)^sign(b) and the remainder sign SHALL be sign(a).
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0 (wrap, no trap).
REQ-024 A divide with src_b=0 SHALL NOT enter CALC: state stays IDLE, HI/LO are unchanged, and done and div_by_zero pulse in the cycle after E0.
REQ-025 start while busy SHALL be ignored.
REQ-026 start with flush in the same cycle SHALL be ignored.
REQ-027 flush while busy SHALL return the FSM to IDLE at the next edge with HI/LO unchanged and no done pulse.
REQ-028 hi_we/lo_we SHALL update hi/lo from wdata at the next edge only when state=IDLE; they SHALL be ignored while busy.
REQ-029 hi_we/lo_we in the same cycle as an accepted start SHALL be applied at E0; the operation result later overwrites HI/LO.
REQ-030 hi and lo SHALL change only at FIX, at an applied hi_we/lo_we, or on reset.

Reset
REQ-031 reset=0 SHALL immediately force state=IDLE, count=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0, regardless of clk.
REQ-032 Reset during CALC or FIX SHALL discard the operation; no done pulse SHALL follow reset release.

Configuration
REQ-033 Macro MULDIV_FAST_MUL_EN, when defined, SHALL compute MULT/MULTU with a single-cycle combinational multiplier: HI/LO are written at E0, done pulses the cycle after E0, busy never asserts, and stall = start & ~flush.
REQ-034 Without MULDIV_FAST_MUL_EN, multiply SHALL use the iterative 34-edge path of REQ-017..REQ-019.
REQ-035 Divide SHALL be iterative in both configurations.

Verification
REQ-036 MULT 0xFFFFFFFF x 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; busy high E0..E33; done the cycle after E33.
REQ-037 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-038 DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 2 -> LO=3, HI=1.
REQ-039 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5 / 0 -> div_by_zero=1 and done=1 the cycle after E0, busy stays 0, HI/LO unchanged.
REQ-040 hi_we=1, wdata=0x12345678 in IDLE, then MULTU 3 x 4 with flush at E10 -> hi=0x12345678, lo unchanged, no done; a repeated start after the flush completes normally with LO=12.
REQ-041 reset=0 asserted at E20 of a divide -> all outputs 0 immediately; after release there is no done pulse and hi=lo=0.
